// File: rtl/spike_aer_transmitter.sv
// -----------------------------------------------------------------------------
// spike_aer_transmitter
//
// Transmit end of the spike path. Each cycle the spike vector from the neuron
// network is sampled into a per-neuron capture stage (one pending bit plus the
// timestamp at which it fired). The lowest-index pending neuron is moved into
// an event FIFO each cycle. A small FSM drains the FIFO off-block over a
// 4-phase req/ack AER link.
//
// Ports
//   clk           in   clock, all logic on posedge
//   reset         in   asynchronous, active-high reset
//   enable        in   1: sample spikes_in and advance the timestamp
//   spikes_in     in   [N_NEURONS]   bit i = neuron i fired this cycle
//   aer_req       out  4-phase request (registered)
//   aer_ack       in   4-phase acknowledge, already synchronous to clk
//   aer_addr      out  [ADDR_WIDTH]  neuron index of the current event
//   aer_ts        out  [TS_WIDTH]    timestamp of the current event
//   fifo_count    out  [clog2(D)+1]  queued events, 0..FIFO_DEPTH
//   overflow      out  sticky flag, set when any spike is dropped
//   drop_count    out  [8]           saturating count of dropped spikes
//   clear_status  in   synchronous clear of overflow and drop_count
// -----------------------------------------------------------------------------
module spike_aer_transmitter #(
  parameter int unsigned N_NEURONS  = 3,
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned TS_WIDTH   = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [N_NEURONS-1:0]  spikes_in,
  output logic                  aer_req,
  input  logic                  aer_ack,
  output logic [ADDR_WIDTH-1:0] aer_addr,
  output logic [TS_WIDTH-1:0]   aer_ts,
  output logic [CNT_WIDTH-1:0]  fifo_count,
  output logic                  overflow,
  output logic [7:0]            drop_count,
  input  logic                  clear_status
);

  localparam int unsigned PtrWidth = $clog2(FIFO_DEPTH);
  localparam int unsigned EvWidth  = TS_WIDTH + ADDR_WIDTH;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StAckLo
  } state_e;

  // ---------------------------------------------------------------------------
  // Free-running timestamp
  // ---------------------------------------------------------------------------
  logic [TS_WIDTH-1:0] ts_q, ts_d;

  always_comb begin
    ts_d = ts_q;
    if (enable) begin
      ts_d = ts_q + TS_WIDTH'(1);  // wraps naturally at 2**TS_WIDTH
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO pointers (one extra bit distinguishes full from empty)
  // ---------------------------------------------------------------------------
  logic [PtrWidth:0]  wr_ptr_q, rd_ptr_q;
  logic [EvWidth-1:0] mem_q [FIFO_DEPTH];
  logic [CNT_WIDTH-1:0] count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push_en;
  logic               pop_en;

  assign count      = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = (count == CNT_WIDTH'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  // ---------------------------------------------------------------------------
  // Capture and push stages
  // ---------------------------------------------------------------------------
  logic [N_NEURONS-1:0]  pending_q, pending_d;
  logic [TS_WIDTH-1:0]   ts_lat_q [N_NEURONS];
  logic [TS_WIDTH-1:0]   ts_lat_d [N_NEURONS];
  logic [N_NEURONS-1:0]  sel_vec;
  logic [N_NEURONS-1:0]  push_vec;
  logic [ADDR_WIDTH-1:0] push_idx;
  logic [TS_WIDTH-1:0]   push_ts;
  logic [N_NEURONS-1:0]  drop_vec;

  // Priority select: scan high to low so the lowest pending index wins.
  always_comb begin
    sel_vec  = '0;
    push_idx = '0;
    push_ts  = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_vec    = '0;
        sel_vec[i] = 1'b1;
        push_idx   = ADDR_WIDTH'(i);
        push_ts    = ts_lat_q[i];
      end
    end
    push_en  = (|pending_q) && !fifo_full;
    push_vec = push_en ? sel_vec : '0;
  end

  // A spike on a neuron that is still pending after this cycle's push is
  // dropped; a neuron being pushed this cycle may re-arm with the new ts.
  always_comb begin
    pending_d = pending_q & ~push_vec;
    ts_lat_d  = ts_lat_q;
    drop_vec  = '0;
    if (enable) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        if (spikes_in[i]) begin
          if (pending_d[i]) begin
            drop_vec[i] = 1'b1;
          end else begin
            pending_d[i] = 1'b1;
            ts_lat_d[i]  = ts_q;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drop status
  // ---------------------------------------------------------------------------
  logic       overflow_q, overflow_d;
  logic [7:0] drop_count_q, drop_count_d;
  logic [8:0] drop_num;
  logic [7:0] drop_base;
  logic [8:0] drop_sum;

  always_comb begin
    drop_num = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      drop_num = drop_num + {8'd0, drop_vec[i]};
    end
    // Clear first, then this cycle's drops are applied on top.
    drop_base  = clear_status ? 8'd0 : drop_count_q;
    overflow_d = clear_status ? 1'b0 : overflow_q;
    if (drop_num != '0) begin
      overflow_d = 1'b1;
    end
    drop_sum     = {1'b0, drop_base} + drop_num;
    drop_count_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [TS_WIDTH-1:0]   out_ts_q, out_ts_d;
  logic [EvWidth-1:0]    head;

  assign head = mem_q[rd_ptr_q[PtrWidth-1:0]];

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    out_ts_d = out_ts_q;
    pop_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A stale ack seen here is ignored; only FIFO occupancy matters.
        if (!fifo_empty) begin
          pop_en   = 1'b1;
          out_ts_d = head[EvWidth-1:ADDR_WIDTH];
          addr_d   = head[ADDR_WIDTH-1:0];
          req_d    = 1'b1;
          state_d  = StReq;
        end
      end
      StReq: begin
        if (aer_ack) begin
          req_d   = 1'b0;
          state_d = StAckLo;
        end
      end
      StAckLo: begin
        if (!aer_ack) begin
          state_d = StIdle;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q         <= '0;
      pending_q    <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        ts_lat_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      state_q      <= StIdle;
      req_q        <= 1'b0;
      addr_q       <= '0;
      out_ts_q     <= '0;
    end else begin
      ts_q         <= ts_d;
      pending_q    <= pending_d;
      ts_lat_q     <= ts_lat_d;
      if (push_en) begin
        wr_ptr_q <= wr_ptr_q + (PtrWidth + 1)'(1);
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + (PtrWidth + 1)'(1);
      end
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      state_q      <= state_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      out_ts_q     <= out_ts_d;
    end
  end

  // Storage needs no reset: occupancy is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q[PtrWidth-1:0]] <= {push_ts, push_idx};
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign aer_req    = req_q;
  assign aer_addr   = addr_q;
  assign aer_ts     = out_ts_q;
  assign fifo_count = count;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_spike_aer_transmitter.sv
// -----------------------------------------------------------------------------
// tb_spike_aer_transmitter
//
// Randomised and directed stimulus for spike_aer_transmitter. A queue-based
// reference model predicts the event stream and status; a separate monitor
// compares every event the DUT presents on the AER link against the
// scoreboard queue, and the status outputs against the model each cycle.
// -----------------------------------------------------------------------------
module tb_spike_aer_transmitter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] spikes_in = '0;
  logic       aer_ack = 1'b0;
  logic       clear_status = 1'b0;
  logic       aer_req;
  logic [1:0] aer_addr;
  logic [7:0] aer_ts;
  logic [3:0] fifo_count;
  logic       overflow;
  logic [7:0] drop_count;

  always #5 clk = ~clk;

  spike_aer_transmitter #(
    .N_NEURONS (3),
    .ADDR_WIDTH(2),
    .TS_WIDTH  (8),
    .FIFO_DEPTH(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .spikes_in   (spikes_in),
    .aer_req     (aer_req),
    .aer_ack     (aer_ack),
    .aer_addr    (aer_addr),
    .aer_ts      (aer_ts),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .clear_status(clear_status)
  );

  typedef struct packed {
    logic [7:0] ts;
    logic [1:0] addr;
  } ev_t;

  ev_t exp_q[$];   // scoreboard: events in the order they must appear
  ev_t m_fifo[$];  // model of the event queue occupancy

  int errors = 0;
  int checks = 0;

  // Reference model state (value after the most recent modelled edge).
  int       m_ts;
  bit [2:0] m_pend;
  int       m_lts[3];
  int       m_phase;  // 0 idle, 1 request up, 2 waiting for ack release
  bit       m_ovf;
  int       m_drop;
  int       m_addr;
  int       m_tsout;

  bit chk_en = 1'b0;
  bit stall = 1'b0;
  int ack_max = 0;
  int rcv_wait = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_ts = 0;
    m_pend = '0;
    for (int i = 0; i < 3; i++) m_lts[i] = 0;
    m_phase = 0;
    m_ovf = 1'b0;
    m_drop = 0;
    m_addr = 0;
    m_tsout = 0;
    m_fifo.delete();
    exp_q.delete();
  endtask

  // Advance the model across the next rising edge using the driven inputs.
  task automatic model_step();
    int  pj;
    int  drops;
    bit  pop;
    ev_t e;
    pj = -1;
    if (m_fifo.size() < 8) begin
      for (int j = 2; j >= 0; j--) if (m_pend[j]) pj = j;
    end
    pop = (m_phase == 0) && (m_fifo.size() > 0);
    case (m_phase)
      0: m_phase = pop ? 1 : 0;
      1: m_phase = aer_ack ? 2 : 1;
      default: m_phase = aer_ack ? 2 : 0;
    endcase
    if (pop) begin
      e = m_fifo.pop_front();
      m_addr = int'(e.addr);
      m_tsout = int'(e.ts);
    end
    if (pj >= 0) begin
      e.ts = 8'(m_lts[pj]);
      e.addr = 2'(pj);
      m_fifo.push_back(e);
      exp_q.push_back(e);
      m_pend[pj] = 1'b0;
    end
    drops = 0;
    if (enable) begin
      for (int i = 0; i < 3; i++) begin
        if (spikes_in[i]) begin
          if (m_pend[i]) drops++;
          else begin
            m_pend[i] = 1'b1;
            m_lts[i] = m_ts;
          end
        end
      end
    end
    if (clear_status) begin
      m_ovf = 1'b0;
      m_drop = 0;
    end
    if (drops > 0) begin
      m_ovf = 1'b1;
      m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
    end
    if (enable) m_ts = (m_ts + 1) % 256;
  endtask

  // One cycle: at the falling edge play the receiver, drive inputs, model.
  task automatic drive(input bit en, input bit [2:0] spk, input bit clr);
    @(negedge clk);
    if (aer_ack != aer_req) begin
      if (aer_req && stall) begin
        // receiver withholding ack
      end else if (rcv_wait > 0) begin
        rcv_wait--;
      end else begin
        aer_ack = aer_req;
        rcv_wait = $urandom_range(0, ack_max);
      end
    end
    enable = en;
    spikes_in = spk;
    clear_status = clr;
    model_step();
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic do_reset();
    #3;
    reset = 1'b1;
    chk_en = 1'b0;
    #1;
    check("reset aer_req", 32'(aer_req), 32'd0);
    check("reset fifo_count", 32'(fifo_count), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    check("reset drop_count", 32'(drop_count), 32'd0);
    check("reset aer_addr", 32'(aer_addr), 32'd0);
    check("reset aer_ts", 32'(aer_ts), 32'd0);
    model_reset();
    aer_ack = 1'b0;
    enable = 1'b0;
    spikes_in = '0;
    clear_status = 1'b0;
    stall = 1'b0;
    rcv_wait = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_step();
    chk_en = 1'b1;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 400; k++) begin
      if (exp_q.size() == 0 && m_fifo.size() == 0 && m_pend == 3'b000 && m_phase == 0) break;
      drive(1'b1, 3'b000, 1'b0);
    end
    check("drain outstanding events", exp_q.size(), 32'd0);
  endtask

  // Monitor: per-cycle status, plus scoreboard pop on each new request.
  bit prev_req = 1'b0;
  always @(posedge clk) begin : monitor
    ev_t e;
    #1;
    if (chk_en && !reset) begin
      check("aer_req", 32'(aer_req), 32'(m_phase == 1));
      check("fifo_count", 32'(fifo_count), m_fifo.size());
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("drop_count", 32'(drop_count), m_drop);
      check("aer_addr hold", 32'(aer_addr), m_addr);
      check("aer_ts hold", 32'(aer_ts), m_tsout);
      if (aer_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected event: got addr %0d ts %0d expected none at %0t",
                   aer_addr, aer_ts, $time);
        end else begin
          e = exp_q.pop_front();
          check("event addr", 32'(aer_addr), 32'(e.addr));
          check("event ts", 32'(aer_ts), 32'(e.ts));
        end
      end
    end
    prev_req = aer_req;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    do_reset();

    // Single spike on neuron 1 at ts=5, prompt ack.
    ack_max = 0;
    while (m_ts != 5) drive(1'b1, 3'b000, 1'b0);
    drive(1'b1, 3'b010, 1'b0);
    repeat (12) drive(1'b1, 3'b000, 1'b0);

    // Simultaneous spikes: addresses 0,1,2 with a common ts.
    drive(1'b1, 3'b111, 1'b0);
    repeat (20) drive(1'b1, 3'b000, 1'b0);

    // Back-pressure: FIFO fills, then one drop per cycle; then clear.
    stall = 1'b1;
    repeat (25) drive(1'b1, 3'b001, 1'b0);
    drive(1'b1, 3'b000, 1'b1);
    stall = 1'b0;
    drain();

    // Timestamp wrap, then freeze with enable low.
    while (m_ts != 255) drive(1'b1, 3'b000, 1'b0);
    drive(1'b1, 3'b001, 1'b0);
    drive(1'b1, 3'b001, 1'b0);
    repeat (10) drive(1'b0, 3'($urandom), 1'b0);
    drive(1'b1, 3'b100, 1'b0);
    drain();

    // Randomised traffic with varying ack latency and stalls.
    for (int c = 0; c < 3000; c++) begin
      bit       en;
      bit [2:0] spk;
      bit       clr;
      if ((c % 200) == 0) ack_max = $urandom_range(0, 3);
      if ($urandom_range(0, 99) == 0) stall = !stall;
      en = ($urandom_range(0, 9) != 0);
      spk = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      clr = ($urandom_range(0, 49) == 0);
      drive(en, spk, clr);
    end
    stall = 1'b0;
    drain();

    // Reset while a request is outstanding, then normal operation resumes.
    stall = 1'b1;
    drive(1'b1, 3'b100, 1'b0);
    for (int k = 0; k < 20 && !aer_req; k++) drive(1'b1, 3'b000, 1'b0);
    check("request raised before reset", 32'(aer_req), 32'd1);
    do_reset();
    ack_max = 0;
    drive(1'b1, 3'b001, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
